// File: rtl/ikascc_rom_arb.sv
// Shares the external ROM/flash byte port between slot CPU reads and host loader writes,
// with a synchronized CPU strobe, WAIT generation and a bounded memory handshake.
module ikascc_rom_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        emuclk,
  input  logic        rst_n,
  input  logic        cpu_romcs_n,
  input  logic [5:0]  cpu_bank,
  input  logic [12:0] cpu_ab,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_wait_n,
  input  logic        ld_req,
  input  logic [18:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_ack,
  output logic        ld_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [18:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CPU_ACC  = 2'd1;
  localparam logic [1:0] S_LD_ACC   = 2'd2;
  localparam logic [1:0] S_CPU_HOLD = 2'd3;

  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state, state_nx;
  logic [1:0]    csz;
  logic          csz_d;
  logic          cpu_pend, cpu_pend_nx;
  logic [AW-1:0] cpu_addr, cpu_addr_nx;
  logic          last_cpu, last_cpu_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic [DW-1:0] cpu_rdata_nx;
  logic          cpu_wait_n_nx;
  logic          ld_ack_nx, ld_err_nx;
  logic          mem_req_nx, mem_we_nx;
  logic [AW-1:0] mem_addr_nx;
  logic [DW-1:0] mem_wdata_nx;

  logic cs_fall_c;
  logic ld_ok_c;
  logic acc_done_c;

  // Falling edge of the synchronized strobe; csz_d holds the previous synchronized value.
  assign cs_fall_c  = csz_d & ~csz[1];
  // The ack cycle masks ld_req so a loader that drops it late is not granted twice.
  assign ld_ok_c    = ld_req & ~ld_ack;
  assign acc_done_c = mem_ack | (cnt == TMO_LAST);

  always_ff @(posedge emuclk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      csz        <= 2'b11;
      csz_d      <= 1'b1;
      cpu_pend   <= 1'b0;
      cpu_addr   <= '0;
      last_cpu   <= 1'b0;
      cnt        <= '0;
      cpu_rdata  <= 8'hFF;
      cpu_wait_n <= 1'b1;
      ld_ack     <= 1'b0;
      ld_err     <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nx;
      csz        <= {csz[0], cpu_romcs_n};
      csz_d      <= csz[1];
      cpu_pend   <= cpu_pend_nx;
      cpu_addr   <= cpu_addr_nx;
      last_cpu   <= last_cpu_nx;
      cnt        <= cnt_nx;
      cpu_rdata  <= cpu_rdata_nx;
      cpu_wait_n <= cpu_wait_n_nx;
      ld_ack     <= ld_ack_nx;
      ld_err     <= ld_err_nx;
      mem_req    <= mem_req_nx;
      mem_we     <= mem_we_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_nx      = state;
    cpu_pend_nx   = cpu_pend;
    cpu_addr_nx   = cpu_addr;
    last_cpu_nx   = last_cpu;
    cnt_nx        = cnt;
    cpu_rdata_nx  = cpu_rdata;
    cpu_wait_n_nx = cpu_pend ? 1'b0 : cpu_wait_n;
    ld_ack_nx     = 1'b0;
    ld_err_nx     = 1'b0;
    mem_req_nx    = mem_req;
    mem_we_nx     = mem_we;
    mem_addr_nx   = mem_addr;
    mem_wdata_nx  = mem_wdata;

    if (cs_fall_c && !cpu_pend) begin
      cpu_pend_nx = 1'b1;
      cpu_addr_nx = {cpu_bank, cpu_ab};
    end

    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (cpu_pend && (!ld_ok_c || !last_cpu)) begin
          state_nx    = S_CPU_ACC;
          cpu_pend_nx = 1'b0;
          mem_req_nx  = 1'b1;
          mem_we_nx   = 1'b0;
          mem_addr_nx = cpu_addr;
        end else if (ld_ok_c) begin
          state_nx     = S_LD_ACC;
          mem_req_nx   = 1'b1;
          mem_we_nx    = 1'b1;
          mem_addr_nx  = ld_addr;
          mem_wdata_nx = ld_data;
        end
      end
      S_CPU_ACC: begin
        cnt_nx = cnt + CW'(1);
        if (acc_done_c) begin
          cpu_rdata_nx  = mem_ack ? mem_rdata : 8'hFF;
          cpu_wait_n_nx = 1'b1;
          mem_req_nx    = 1'b0;
          last_cpu_nx   = 1'b1;
          state_nx      = csz[1] ? S_IDLE : S_CPU_HOLD;
        end
      end
      S_LD_ACC: begin
        cnt_nx = cnt + CW'(1);
        if (acc_done_c) begin
          ld_ack_nx   = 1'b1;
          ld_err_nx   = ~mem_ack;
          mem_req_nx  = 1'b0;
          last_cpu_nx = 1'b0;
          state_nx    = S_IDLE;
        end
      end
      S_CPU_HOLD: begin
        if (csz[1]) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
